// File: rtl/counter_seq_ctrl.sv
// Command sequencer for the MOD-14 up/down counter. It freezes the counter between commands
// by reloading a shadow count, and it flags any divergence between the counter and that shadow.
module counter_seq_ctrl #(
  parameter int MOD   = 14,
  parameter int CNT_W = 4,
  parameter int LEN_W = 8
) (
  input  logic             clock,
  input  logic             rest,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_data,
  input  logic [LEN_W-1:0] cmd_len,
  output logic [CNT_W-1:0] cnt_data_in,
  output logic             cnt_load,
  output logic             cnt_mode,
  output logic             cnt_rest,
  input  logic [CNT_W-1:0] cnt_data_out,
  output logic [CNT_W-1:0] count_val,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic             err_cmd,
  output logic             err_mismatch
);

  typedef enum logic {IDLE, COUNT} state_t;

  localparam logic [1:0]       OP_LOAD  = 2'b00;
  localparam logic [1:0]       OP_UP    = 2'b01;
  localparam logic [1:0]       OP_DOWN  = 2'b10;
  localparam logic [1:0]       OP_CLEAR = 2'b11;
  localparam logic [CNT_W-1:0] MAX_VAL  = CNT_W'(MOD - 1);
  localparam logic [CNT_W:0]   MOD_EXT  = (CNT_W + 1)'(MOD);

  state_t             state;
  logic [CNT_W-1:0]   shadow;
  logic [LEN_W-1:0]   remaining;
  logic               dir;
  logic               armed;

  logic               accept;
  logic               is_count_op;
  logic               load_over;
  logic [CNT_W-1:0]   load_val;
  logic               step_en;
  logic               step_up;
  logic               step_wrap;
  logic [CNT_W-1:0]   step_next;

  assign cmd_ready   = rest & (state == IDLE);
  assign accept      = cmd_valid & cmd_ready;
  assign is_count_op = (cmd_op == OP_UP) || (cmd_op == OP_DOWN);
  assign load_over   = {1'b0, cmd_data} >= MOD_EXT;
  assign load_val    = load_over ? MAX_VAL : cmd_data;

  // The acceptance cycle of a non-empty UP/DOWN already counts one step.
  assign step_en   = (state == COUNT) || (accept && is_count_op && (cmd_len != '0));
  assign step_up   = (state == COUNT) ? dir : (cmd_op == OP_UP);
  assign step_wrap = step_up ? (shadow == MAX_VAL) : (shadow == '0);

  always_comb begin
    step_next = shadow;
    if (step_up)
      step_next = step_wrap ? '0 : shadow + CNT_W'(1);
    else
      step_next = step_wrap ? MAX_VAL : shadow - CNT_W'(1);
  end

  // Counter drive is combinational so the counter moves on the same edge as the shadow.
  always_comb begin
    cnt_data_in = shadow;
    cnt_load    = 1'b1;
    cnt_mode    = dir;
    cnt_rest    = rest & ~(accept && (cmd_op == OP_CLEAR));
    if (state == COUNT) begin
      cnt_load = 1'b0;
    end else if (accept) begin
      case (cmd_op)
        OP_LOAD:  cnt_data_in = load_val;
        OP_CLEAR: cnt_load    = 1'b0;
        default: begin
          if (cmd_len != '0) begin
            cnt_load = 1'b0;
            cnt_mode = (cmd_op == OP_UP);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!rest) begin
      state        <= IDLE;
      shadow       <= '0;
      remaining    <= '0;
      dir          <= 1'b0;
      armed        <= 1'b0;
      done         <= 1'b0;
      wrap         <= 1'b0;
      err_cmd      <= 1'b0;
      err_mismatch <= 1'b0;
    end else begin
      done    <= 1'b0;
      wrap    <= 1'b0;
      err_cmd <= 1'b0;
      armed   <= 1'b1;
      if (armed && (cnt_data_out != shadow))
        err_mismatch <= 1'b1;
      if (step_en) begin
        shadow <= step_next;
        wrap   <= step_wrap;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            case (cmd_op)
              OP_LOAD: begin
                shadow  <= load_val;
                err_cmd <= load_over;
                done    <= 1'b1;
              end
              OP_CLEAR: begin
                shadow <= '0;
                done   <= 1'b1;
              end
              default: begin
                if (cmd_len == '0) begin
                  done <= 1'b1;
                end else begin
                  remaining <= cmd_len - LEN_W'(1);
                  dir       <= (cmd_op == OP_UP);
                  if (cmd_len != LEN_W'(1))
                    state <= COUNT;
                  else
                    done <= 1'b1;
                end
              end
            endcase
          end
        end
        COUNT: begin
          // Leaving on remaining<=1 keeps the down-count from ever wrapping below zero.
          if (remaining <= LEN_W'(1)) begin
            remaining <= '0;
            state     <= IDLE;
            done      <= 1'b1;
          end else begin
            remaining <= remaining - LEN_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign count_val = shadow;
  assign busy      = (state == COUNT);

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl: a behavioural MOD-14 counter closes the loop, and a scoreboard
// of expected command completions is checked by a monitor whenever done pulses.
module tb_counter_seq_ctrl;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_UP    = 2'b01;
  localparam logic [1:0] OP_DOWN  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic       clock = 1'b0;
  logic       rest;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [7:0] cmd_len;
  logic [3:0] cnt_data_in;
  logic       cnt_load;
  logic       cnt_mode;
  logic       cnt_rest;
  logic [3:0] cnt_data_out;
  logic [3:0] count_val;
  logic       busy;
  logic       done;
  logic       wrap;
  logic       err_cmd;
  logic       err_mismatch;

  logic [3:0] ctr;
  logic       force_five;

  typedef struct {
    logic [3:0] count;
    logic       err;
    int         wraps;
    int         busy_cycles;
  } exp_t;

  exp_t sb[$];
  exp_t popped;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   wrap_acc = 0;
  int   busy_acc = 0;

  always #5 clock = ~clock;

  counter_seq_ctrl #(.MOD(14), .CNT_W(4), .LEN_W(8)) dut (
    .clock        (clock),
    .rest         (rest),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .cmd_len      (cmd_len),
    .cnt_data_in  (cnt_data_in),
    .cnt_load     (cnt_load),
    .cnt_mode     (cnt_mode),
    .cnt_rest     (cnt_rest),
    .cnt_data_out (cnt_data_out),
    .count_val    (count_val),
    .busy         (busy),
    .done         (done),
    .wrap         (wrap),
    .err_cmd      (err_cmd),
    .err_mismatch (err_mismatch)
  );

  // Behavioural MOD-14 up/down counter; force_five corrupts its output for the checker test.
  always_ff @(posedge clock) begin
    if (!cnt_rest)
      ctr <= 4'd0;
    else if (cnt_load)
      ctr <= cnt_data_in;
    else if (cnt_mode)
      ctr <= (ctr == 4'd13) ? 4'd0 : ctr + 4'd1;
    else
      ctr <= (ctr == 4'd0) ? 4'd13 : ctr - 4'd1;
  end

  assign cnt_data_out = force_five ? 4'd5 : ctr;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected)
      n_pass++;
    else
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Monitor: accumulates wrap/busy cycles and pops one scoreboard entry per done pulse.
  always @(negedge clock) begin
    if (!rest) begin
      wrap_acc = 0;
      busy_acc = 0;
    end else begin
      if (wrap) wrap_acc++;
      if (busy) busy_acc++;
      if (done) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          popped = sb.pop_front();
          checkOutput("done_count_val", 32'(count_val), 32'(popped.count));
          checkOutput("done_cnt_data_out", 32'(cnt_data_out), 32'(popped.count));
          checkOutput("done_err_cmd", 32'(err_cmd), 32'(popped.err));
          checkOutput("done_wraps", wrap_acc, popped.wraps);
          checkOutput("done_busy_cycles", busy_acc, popped.busy_cycles);
        end
        wrap_acc = 0;
        busy_acc = 0;
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] op, input logic [3:0] data, input logic [7:0] len,
                               input bit push, input logic [3:0] exp_count, input bit exp_err,
                               input int exp_wraps, input int exp_busy);
    int   guard = 0;
    exp_t e;
    bit   exp_load;
    bit   exp_done_next;
    @(posedge clock); #1;
    while (!cmd_ready && guard < 500) begin
      @(posedge clock); #1;
      guard++;
    end
    if (!cmd_ready) begin
      checkOutput("ready_timeout", 32'd0, 32'd1);
      return;
    end
    cmd_op    = op;
    cmd_data  = data;
    cmd_len   = len;
    cmd_valid = 1'b1;
    if (push) begin
      e.count       = exp_count;
      e.err         = exp_err;
      e.wraps       = exp_wraps;
      e.busy_cycles = exp_busy;
      sb.push_back(e);
    end
    exp_load      = (op == OP_LOAD) || ((op != OP_CLEAR) && (len == 8'd0));
    exp_done_next = (op == OP_LOAD) || (op == OP_CLEAR) || (len <= 8'd1);
    #1;
    checkOutput("accept_cnt_rest", 32'(cnt_rest), 32'(op != OP_CLEAR));
    checkOutput("accept_cnt_load", 32'(cnt_load), 32'(exp_load));
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    checkOutput("done_timing", 32'(done), 32'(exp_done_next));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rest       = 1'b0;
    cmd_valid  = 1'b0;
    cmd_op     = 2'b00;
    cmd_data   = 4'd0;
    cmd_len    = 8'd0;
    force_five = 1'b0;

    repeat (3) begin
      @(posedge clock); #2;
      checkOutput("rst_cnt_rest", 32'(cnt_rest), 32'd0);
      checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      checkOutput("rst_count_val", 32'(count_val), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
    end
    rest = 1'b1;
    #1;
    checkOutput("rel_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clock); #2;
    checkOutput("rel_cnt_data_out", 32'(cnt_data_out), 32'd0);

    $display("[TB] LOAD 9 then idle");
    applyStimulus(OP_LOAD, 4'd9, 8'd0, 1'b1, 4'd9, 1'b0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      #1;
      checkOutput("hold9_count_val", 32'(count_val), 32'd9);
      checkOutput("hold9_cnt_data_out", 32'(cnt_data_out), 32'd9);
      checkOutput("hold9_err_mismatch", 32'(err_mismatch), 32'd0);
      @(posedge clock); #1;
    end

    $display("[TB] LOAD 12, UP 3");
    applyStimulus(OP_LOAD, 4'd12, 8'd0, 1'b1, 4'd12, 1'b0, 0, 0);
    applyStimulus(OP_UP, 4'd0, 8'd3, 1'b1, 4'd1, 1'b0, 1, 2);
    #1;
    checkOutput("up_step1", 32'(cnt_data_out), 32'd13);
    @(posedge clock); #2;
    checkOutput("up_step2", 32'(cnt_data_out), 32'd0);
    @(posedge clock); #2;
    checkOutput("up_step3", 32'(cnt_data_out), 32'd1);
    @(posedge clock); #2;
    checkOutput("up_hold", 32'(cnt_data_out), 32'd1);

    $display("[TB] LOAD 1, DOWN 3");
    applyStimulus(OP_LOAD, 4'd1, 8'd0, 1'b1, 4'd1, 1'b0, 0, 0);
    applyStimulus(OP_DOWN, 4'd0, 8'd3, 1'b1, 4'd12, 1'b0, 1, 2);
    #1;
    checkOutput("down_step1", 32'(cnt_data_out), 32'd0);
    @(posedge clock); #2;
    checkOutput("down_step2", 32'(cnt_data_out), 32'd13);
    @(posedge clock); #2;
    checkOutput("down_step3", 32'(cnt_data_out), 32'd12);
    repeat (3) begin
      @(posedge clock); #2;
      checkOutput("down_hold", 32'(cnt_data_out), 32'd12);
      checkOutput("down_hold_err_mismatch", 32'(err_mismatch), 32'd0);
    end

    $display("[TB] LOAD 15 clamp, UP 0, CLEAR");
    applyStimulus(OP_LOAD, 4'd15, 8'd0, 1'b1, 4'd13, 1'b1, 0, 0);
    #1;
    checkOutput("clamp_count_val", 32'(count_val), 32'd13);
    applyStimulus(OP_UP, 4'd0, 8'd0, 1'b1, 4'd13, 1'b0, 0, 0);
    #1;
    checkOutput("len0_count_val", 32'(count_val), 32'd13);
    applyStimulus(OP_CLEAR, 4'd0, 8'd0, 1'b1, 4'd0, 1'b0, 0, 0);
    #1;
    checkOutput("clear_cnt_rest_after", 32'(cnt_rest), 32'd1);
    checkOutput("clear_count_val", 32'(count_val), 32'd0);
    @(posedge clock); #2;
    checkOutput("clear_cnt_data_out", 32'(cnt_data_out), 32'd0);

    $display("[TB] UP 200 aborted by reset, then checker");
    applyStimulus(OP_UP, 4'd0, 8'd200, 1'b0, 4'd0, 1'b0, 0, 0);
    repeat (49) @(posedge clock);
    #1;
    checkOutput("abort_pre_count_val", 32'(count_val), 32'd8);
    checkOutput("abort_pre_busy", 32'(busy), 32'd1);
    rest = 1'b0;
    #1;
    checkOutput("abort_cnt_rest", 32'(cnt_rest), 32'd0);
    repeat (2) @(posedge clock);
    #2;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_count_val", 32'(count_val), 32'd0);
    checkOutput("abort_cmd_ready", 32'(cmd_ready), 32'd0);
    rest = 1'b1;
    repeat (5) @(posedge clock);
    #2;
    checkOutput("post_abort_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("post_abort_cnt_data_out", 32'(cnt_data_out), 32'd0);
    checkOutput("post_abort_err_mismatch", 32'(err_mismatch), 32'd0);
    force_five = 1'b1;
    @(posedge clock); #2;
    force_five = 1'b0;
    checkOutput("mismatch_set", 32'(err_mismatch), 32'd1);
    repeat (3) begin
      @(posedge clock); #2;
      checkOutput("mismatch_sticky", 32'(err_mismatch), 32'd1);
    end

    repeat (3) @(posedge clock);
    #2;
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
